// File: rtl/hex_line_formatter.sv
// hex_line_formatter: serialises an (X, Y) sample as the ASCII hex line "XXXX,YYYY\r\n" on a valid/ready byte stream.
// Defining HEX_FMT_CHECKSUM_EN appends ",CC" (XOR of the X, separator and Y characters) before CR.
module hex_line_formatter #(
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] SEP_CHAR   = 8'h2C
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iVALID,
    output logic                  oREADY,
    input  logic [DATA_WIDTH-1:0] iX,
    input  logic [DATA_WIDTH-1:0] iY,
    output logic [7:0]            oTX_DATA,
    output logic                  oTX_VALID,
    input  logic                  iTX_READY,
    output logic [7:0]            oDROP_CNT,
    output logic                  oBUSY
);
    localparam int NIB = DATA_WIDTH / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    typedef enum logic [3:0] {
        IDLE, X_CHR, SEP, Y_CHR,
`ifdef HEX_FMT_CHECKSUM_EN
        SEP2, CK_HI, CK_LO,
`endif
        CR, LF
    } state_t;
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    logic [NW-1:0]         r_nib;
    logic                  w_xfer;
    logic                  w_last_nib;
    logic [NW-1:0]         w_nib_nxt;
    logic [3:0]            w_x_nib;
    logic [3:0]            w_y_nib;
`ifdef HEX_FMT_CHECKSUM_EN
    logic [7:0]            r_ck;
`endif
    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n <= 4'd9) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
    assign w_xfer     = oTX_VALID && iTX_READY;
    assign w_last_nib = (r_nib == NW'(NIB - 1));
    assign w_nib_nxt  = r_nib + 1'b1;
    // r_nib indexes the nibble currently on oTX_DATA; the next one is looked up ahead of the transfer
    assign w_x_nib    = r_x[(NIB - 1 - int'(w_nib_nxt)) * 4 +: 4];
    assign w_y_nib    = r_y[(NIB - 1 - int'(w_nib_nxt)) * 4 +: 4];
    assign oBUSY      = !oREADY;
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            oREADY    <= 1'b1;
            oTX_VALID <= 1'b0;
            oTX_DATA  <= 8'h00;
            oDROP_CNT <= 8'h00;
            r_nib     <= '0;
            r_x       <= '0;
            r_y       <= '0;
`ifdef HEX_FMT_CHECKSUM_EN
            r_ck      <= 8'h00;
`endif
        end else begin
            if (iVALID && !oREADY && oDROP_CNT != 8'hFF)
                oDROP_CNT <= oDROP_CNT + 1'b1;
`ifdef HEX_FMT_CHECKSUM_EN
            if (w_xfer && (r_state == X_CHR || r_state == SEP || r_state == Y_CHR))
                r_ck <= r_ck ^ oTX_DATA;
`endif
            case (r_state)
                IDLE: if (iVALID) begin
                    r_x       <= iX;
                    r_y       <= iY;
                    r_nib     <= '0;
                    oREADY    <= 1'b0;
                    oTX_VALID <= 1'b1;
                    oTX_DATA  <= hex(iX[DATA_WIDTH-1 -: 4]);
                    r_state   <= X_CHR;
`ifdef HEX_FMT_CHECKSUM_EN
                    r_ck      <= 8'h00;
`endif
                end
                X_CHR: if (w_xfer) begin
                    r_nib    <= w_last_nib ? '0 : w_nib_nxt;
                    oTX_DATA <= w_last_nib ? SEP_CHAR : hex(w_x_nib);
                    r_state  <= w_last_nib ? SEP : X_CHR;
                end
                SEP: if (w_xfer) begin
                    oTX_DATA <= hex(r_y[DATA_WIDTH-1 -: 4]);
                    r_state  <= Y_CHR;
                end
`ifdef HEX_FMT_CHECKSUM_EN
                Y_CHR: if (w_xfer) begin
                    r_nib    <= w_last_nib ? '0 : w_nib_nxt;
                    oTX_DATA <= w_last_nib ? SEP_CHAR : hex(w_y_nib);
                    r_state  <= w_last_nib ? SEP2 : Y_CHR;
                end
                SEP2: if (w_xfer) begin
                    oTX_DATA <= hex(r_ck[7:4]);
                    r_state  <= CK_HI;
                end
                CK_HI: if (w_xfer) begin
                    oTX_DATA <= hex(r_ck[3:0]);
                    r_state  <= CK_LO;
                end
                CK_LO: if (w_xfer) begin
                    oTX_DATA <= 8'h0D;
                    r_state  <= CR;
                end
`else
                Y_CHR: if (w_xfer) begin
                    r_nib    <= w_last_nib ? '0 : w_nib_nxt;
                    oTX_DATA <= w_last_nib ? 8'h0D : hex(w_y_nib);
                    r_state  <= w_last_nib ? CR : Y_CHR;
                end
`endif
                CR: if (w_xfer) begin
                    oTX_DATA <= 8'h0A;
                    r_state  <= LF;
                end
                LF: if (w_xfer) begin
                    oTX_VALID <= 1'b0;
                    oREADY    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hex_line_formatter.sv
// tb_hex_line_formatter: directed and randomized checks of hex_line_formatter against a string-based line model.
// Defining HEX_FMT_CHECKSUM_EN switches the model to the checksum line format.
module tb_hex_line_formatter;
    localparam int DW  = 16;
    localparam int NIB = DW / 4;
`ifdef HEX_FMT_CHECKSUM_EN
    localparam int LEN = 2 * NIB + 6;
`else
    localparam int LEN = 2 * NIB + 3;
`endif
    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          iVALID = 1'b0;
    logic          iTX_READY = 1'b0;
    logic [DW-1:0] iX = '0;
    logic [DW-1:0] iY = '0;
    logic          oREADY;
    logic [7:0]    oTX_DATA;
    logic          oTX_VALID;
    logic [7:0]    oDROP_CNT;
    logic          oBUSY;
    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];

    hex_line_formatter #(.DATA_WIDTH(DW), .SEP_CHAR(8'h2C)) dut (
        .CLK(CLK), .RST(RST), .iVALID(iVALID), .oREADY(oREADY), .iX(iX), .iY(iY),
        .oTX_DATA(oTX_DATA), .oTX_VALID(oTX_VALID), .iTX_READY(iTX_READY),
        .oDROP_CNT(oDROP_CNT), .oBUSY(oBUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected line built as text from the sample values
    function automatic void build(input logic [DW-1:0] x, input logic [DW-1:0] y);
        string      hx = "0123456789ABCDEF";
        logic [7:0] ck = 8'h00;
        exp_q.delete();
        for (int i = NIB - 1; i >= 0; i--) exp_q.push_back(hx[int'((x >> (4 * i)) & 'hF)]);
        exp_q.push_back(8'h2C);
        for (int i = NIB - 1; i >= 0; i--) exp_q.push_back(hx[int'((y >> (4 * i)) & 'hF)]);
`ifdef HEX_FMT_CHECKSUM_EN
        foreach (exp_q[i]) ck ^= exp_q[i];
        exp_q.push_back(8'h2C);
        exp_q.push_back(hx[int'(ck >> 4)]);
        exp_q.push_back(hx[int'(ck & 8'hF)]);
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic accept(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit hold);
        for (int i = 0; i < 100 && !oREADY; i++) tick;
        chk("ready_pre", oREADY, 1);
        chk("valid_pre", oTX_VALID, 0);
        build(x, y);
        iVALID = 1'b1;
        iX = x;
        iY = y;
        tick;
        iVALID = hold;
        chk("first_valid", oTX_VALID, 1);
        chk("busy", oBUSY, 1);
        chk("ready_busy", oREADY, 0);
    endtask

    task automatic drain(input bit rnd, input int stop_at, output int cyc);
        int         stall = 0;
        bit         hv = 0;
        logic [7:0] hd = 8'h00;
        got_q.delete();
        cyc = 0;
        while (got_q.size() < stop_at && cyc < 2000) begin
            if (rnd && stall == 0 && $urandom_range(0, 2) == 0) stall = 4;
            iTX_READY = (stall == 0);
            if (stall > 0) stall--;
            chk("tx_valid_cont", oTX_VALID, 1);
            if (hv) chk("stall_hold", oTX_DATA, hd);
            if (oTX_VALID && iTX_READY) got_q.push_back(oTX_DATA);
            hv = oTX_VALID && !iTX_READY;
            hd = oTX_DATA;
            tick;
            cyc++;
        end
        iTX_READY = 1'b0;
    endtask

    task automatic cmp_line(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) chk(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        chk({tag, "_ready_after"}, oREADY, 1);
        chk({tag, "_valid_after"}, oTX_VALID, 0);
    endtask

    initial begin
        int cyc;
        repeat (2) tick;
        RST = 1'b0;
        chk("rst_ready", oREADY, 1);
        chk("rst_valid", oTX_VALID, 0);
        chk("rst_data", oTX_DATA, 8'h00);
        chk("rst_drop", oDROP_CNT, 0);
        chk("rst_busy", oBUSY, 0);
        accept(16'h1234, 16'hABCD, 0);
        drain(0, LEN, cyc);
        chk("line_cycles", 32'(cyc), 32'(LEN));
        cmp_line("l1234");
        accept(16'h9A0F, 16'h0000, 0);
        drain(0, LEN, cyc);
        cmp_line("l9a0f");
        accept(16'h1234, 16'hABCD, 0);
        drain(1, LEN, cyc);
        cmp_line("bp1234");
        for (int k = 0; k < 6; k++) begin
            accept(DW'($urandom), DW'($urandom), 0);
            drain(k[0], LEN, cyc);
            cmp_line("rand");
        end
        accept(16'hFFFF, 16'hF00F, 0);
        drain(1, LEN, cyc);
        cmp_line("lffff");
        chk("no_drops", oDROP_CNT, 0);
        accept(16'h5A5A, 16'hC3C3, 1);
        drain(0, LEN, cyc);
        chk("drop_lf", oDROP_CNT, 32'(LEN));
        cmp_line("lf_line");
        tick;
        iVALID = 1'b0;
        chk("lf_reaccept", oBUSY, 1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("rst2_drop", oDROP_CNT, 0);
        accept(16'hBEEF, 16'h0123, 1);
        repeat (300) tick;
        chk("drop_sat", oDROP_CNT, 8'hFF);
        chk("drop_data_hold", oTX_DATA, 32'(exp_q[0]));
        chk("drop_busy", oREADY, 0);
        iVALID = 1'b0;
        drain(0, LEN, cyc);
        cmp_line("drop_line");
        repeat (3) tick;
        chk("single_accept", oTX_VALID, 0);
        chk("drop_keep", oDROP_CNT, 8'hFF);
        accept(16'h0F1E, 16'h2D3C, 0);
        drain(0, 5, cyc);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("mid_valid", oTX_VALID, 0);
        chk("mid_ready", oREADY, 1);
        chk("mid_drop", oDROP_CNT, 0);
        chk("mid_data", oTX_DATA, 8'h00);
        for (int i = 0; i < 5; i++) chk("mid_prefix", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        tick;
        chk("mid_quiet", oTX_VALID, 0);
        accept(16'h7E57, 16'hC0DE, 0);
        drain(1, LEN, cyc);
        cmp_line("post_rst");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
